// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel type and arbiter state encoding.
package fb_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W   = 19;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Row-major pixel address: y*H_ACTIVE + x, truncated to ADDR_W bits.
// With H_ACTIVE=640 the constant multiply reduces to (y<<9)+(y<<7)+x.
module fb_addr_calc #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int ADDR_W   = fb_pkg::ADDR_W
) (
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    output logic [ADDR_W-1:0] o_addr
);

    assign o_addr = ADDR_W'(32'(i_y) * 32'(H_ACTIVE) + 32'(i_x));

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win every cycle, the
// clear sweep and raster writes fill the RAM cycles scan-out leaves idle.
module fb_access_arbiter #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
    parameter int ADDR_W   = fb_pkg::ADDR_W,
    parameter int DROP_W   = 16
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              scan_req,
    input  logic [9:0]        scan_x,
    input  logic [8:0]        scan_y,
    output logic              scan_rvalid,
    output logic [23:0]       scan_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [8:0]        wr_y,
    input  logic [23:0]       wr_rgb,
    input  logic              clear_start,
    input  logic [23:0]       clear_rgb,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [DROP_W-1:0] drop_count,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata
);

    import fb_pkg::*;

    localparam logic [31:0]       H_U       = 32'(H_ACTIVE);
    localparam logic [31:0]       V_U       = 32'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [ADDR_W-1:0] r_clear_addr;
    logic [ADDR_W-1:0] w_clear_addr_next;
    rgb_t              r_clear_rgb;
    logic              w_latch_clear;

    logic              r_mem_en_p0;
    logic              r_mem_we_p0;
    logic [ADDR_W-1:0] r_mem_addr_p0;
    logic [23:0]       r_mem_wdata_p0;
    logic              r_done_p0;
    logic              r_scan_vld_p0;
    logic              r_scan_vld_p1;
    logic [DROP_W-1:0] r_drop;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [23:0]       w_mem_wdata;
    logic              w_done;
    logic              w_scan_issue;
    logic              w_drop;
    logic              w_wr_hs;
    logic              w_wr_inrange;
    logic [ADDR_W-1:0] w_scan_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    fb_addr_calc #(.H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W)) u_scan_addr (
        .i_x    (scan_x),
        .i_y    (scan_y),
        .o_addr (w_scan_addr)
    );

    fb_addr_calc #(.H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W)) u_wr_addr (
        .i_x    (wr_x),
        .i_y    (wr_y),
        .o_addr (w_wr_addr)
    );

    assign wr_ready     = !scan_req && (r_state == IDLE) && !reset;
    assign w_wr_hs      = wr_valid && wr_ready;
    assign w_wr_inrange = (32'(wr_x) < H_U) && (32'(wr_y) < V_U);

    // Pick this cycle's RAM owner (scan > clear > raster) and the next FSM state.
    always_comb begin
        w_state_next      = r_state;
        w_clear_addr_next = r_clear_addr;
        w_latch_clear     = 1'b0;
        w_mem_en          = 1'b0;
        w_mem_we          = 1'b0;
        w_mem_addr        = r_mem_addr_p0;
        w_mem_wdata       = r_mem_wdata_p0;
        w_done            = 1'b0;
        w_scan_issue      = 1'b0;
        w_drop            = 1'b0;

        if (scan_req) begin
            w_mem_en     = 1'b1;
            w_mem_addr   = w_scan_addr;
            w_scan_issue = 1'b1;
        end else if (r_state == CLEAR) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clear_addr;
            w_mem_wdata = r_clear_rgb;
            if (r_clear_addr == LAST_ADDR) begin
                w_state_next = IDLE;
                w_done       = 1'b1;
            end else begin
                w_clear_addr_next = r_clear_addr + ADDR_W'(1);
            end
        end else if (w_wr_hs) begin
            if (w_wr_inrange) begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_wr_addr;
                w_mem_wdata = wr_rgb;
            end else begin
                w_drop = 1'b1;
            end
        end

        // A clear request only takes effect from IDLE; mid-sweep requests are ignored.
        if ((r_state == IDLE) && clear_start) begin
            w_state_next      = CLEAR;
            w_latch_clear     = 1'b1;
            w_clear_addr_next = '0;
        end
    end

    // FSM state, sweep pointer and latched clear colour.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clear_addr <= '0;
            r_clear_rgb  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_clear_addr <= w_clear_addr_next;
            if (w_latch_clear) begin
                r_clear_rgb <= clear_rgb;
            end
        end
    end

    // Registered RAM port; address and data hold when the port is idle.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_mem_en_p0    <= 1'b0;
            r_mem_we_p0    <= 1'b0;
            r_mem_addr_p0  <= '0;
            r_mem_wdata_p0 <= '0;
            r_done_p0      <= 1'b0;
        end else begin
            r_mem_en_p0    <= w_mem_en;
            r_mem_we_p0    <= w_mem_we;
            r_mem_addr_p0  <= w_mem_addr;
            r_mem_wdata_p0 <= w_mem_wdata;
            r_done_p0      <= w_done;
        end
    end

    // Scan read-valid pipeline (fixed two-cycle latency) and saturating drop counter.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_scan_vld_p0 <= 1'b0;
            r_scan_vld_p1 <= 1'b0;
            r_drop        <= '0;
        end else begin
            r_scan_vld_p0 <= w_scan_issue;
            r_scan_vld_p1 <= r_scan_vld_p0;
            if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

    assign mem_en      = r_mem_en_p0;
    assign mem_we      = r_mem_we_p0;
    assign mem_addr    = r_mem_addr_p0;
    assign mem_wdata   = r_mem_wdata_p0;
    assign clear_busy  = (r_state == CLEAR);
    assign clear_done  = r_done_p0;
    assign drop_count  = r_drop;
    assign scan_rvalid = r_scan_vld_p1;
    assign scan_rdata  = r_scan_vld_p1 ? mem_rdata : 24'h0;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: a short frame (640x4) keeps full clear sweeps
// cheap, and a 4-bit drop counter makes saturation reachable.
module tb_fb_access_arbiter;

    localparam int H     = 640;
    localparam int V     = 4;
    localparam int DEPTH = H * V;
    localparam int AW    = 19;
    localparam int DW    = 4;

    logic          pixclk = 1'b0;
    logic          reset;
    logic          scan_req;
    logic [9:0]    scan_x;
    logic [8:0]    scan_y;
    logic          scan_rvalid;
    logic [23:0]   scan_rdata;
    logic          wr_valid;
    logic          wr_ready;
    logic [9:0]    wr_x;
    logic [8:0]    wr_y;
    logic [23:0]   wr_rgb;
    logic          clear_start;
    logic [23:0]   clear_rgb;
    logic          clear_busy;
    logic          clear_done;
    logic [DW-1:0] drop_count;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic [23:0]   mem_rdata;

    always #20 pixclk = ~pixclk;

    fb_access_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DROP_W(DW)) dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .scan_req    (scan_req),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_rvalid (scan_rvalid),
        .scan_rdata  (scan_rdata),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_rgb      (wr_rgb),
        .clear_start (clear_start),
        .clear_rgb   (clear_rgb),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .drop_count  (drop_count),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 1'b0;
    bit wc_clr = 1'b0;

    function automatic logic [23:0] pat(input int a);
        return 24'(a * 32'h010203 + 32'h0A0B0C);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with a per-address write counter.
    logic [23:0] tb_ram [DEPTH];
    int          wcount [DEPTH];
    bit          ram_init = 1'b0;
    always @(posedge pixclk) begin
        if (!ram_init) begin
            for (int i = 0; i < DEPTH; i++) begin
                tb_ram[i] <= pat(i);
                wcount[i] <= 0;
            end
            ram_init <= 1'b1;
        end else if (mem_en && (int'(mem_addr) < DEPTH)) begin
            if (mem_we) begin
                tb_ram[int'(mem_addr)] <= mem_wdata;
                wcount[int'(mem_addr)] <= wcount[int'(mem_addr)] + 1;
            end else begin
                mem_rdata <= tb_ram[int'(mem_addr)];
            end
        end
        if (wc_clr) begin
            for (int i = 0; i < DEPTH; i++) wcount[i] <= 0;
        end
    end

    // Reference model: who owns the RAM this cycle, what the framebuffer holds,
    // and what each registered output must show in the following cycle.
    logic [23:0]   m_fb [DEPTH];
    bit            m_init = 1'b0;
    bit            m_busy;
    int            m_ptr;
    logic [23:0]   m_color;
    int            m_drops;
    bit            e_en, e_we, e_done, e_rv, d1_v;
    logic [AW-1:0] e_addr;
    logic [23:0]   e_wdata, e_rdata, d1_d;

    always @(posedge pixclk) begin
        bit was_busy;
        int a;
        if (!m_init) begin
            for (int i = 0; i < DEPTH; i++) m_fb[i] = pat(i);
            m_init = 1'b1;
        end
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_color = '0; m_drops = 0;
            e_en = 0; e_we = 0; e_done = 0; e_rv = 0; d1_v = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; d1_d = '0;
        end else begin
            was_busy = m_busy;
            e_rv = d1_v; e_rdata = d1_d;
            d1_v = 0; d1_d = '0;
            e_en = 0; e_we = 0; e_done = 0;
            if (scan_req) begin
                a = int'(scan_y) * H + int'(scan_x);
                e_en = 1; e_addr = AW'(a);
                d1_v = 1; d1_d = (a < DEPTH) ? m_fb[a] : 24'h0;
            end else if (was_busy) begin
                e_en = 1; e_we = 1; e_addr = AW'(m_ptr); e_wdata = m_color;
                m_fb[m_ptr] = m_color;
                if (m_ptr == DEPTH - 1) begin
                    m_busy = 0; e_done = 1;
                end else begin
                    m_ptr++;
                end
            end else if (wr_valid) begin
                if (int'(wr_x) < H && int'(wr_y) < V) begin
                    a = int'(wr_y) * H + int'(wr_x);
                    e_en = 1; e_we = 1; e_addr = AW'(a); e_wdata = wr_rgb;
                    m_fb[a] = wr_rgb;
                end else if (m_drops < (1 << DW) - 1) begin
                    m_drops++;
                end
            end
            if (!was_busy && clear_start) begin
                m_busy = 1; m_ptr = 0; m_color = clear_rgb;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge pixclk) begin
        if (chk_en) begin
            chk("mem_en",      32'(mem_en),      32'(e_en));
            chk("mem_we",      32'(mem_we),      32'(e_we));
            chk("mem_addr",    32'(mem_addr),    32'(e_addr));
            chk("mem_wdata",   32'(mem_wdata),   32'(e_wdata));
            chk("scan_rvalid", 32'(scan_rvalid), 32'(e_rv));
            chk("scan_rdata",  32'(scan_rdata),  e_rv ? 32'(e_rdata) : 32'h0);
            chk("wr_ready",    32'(wr_ready),    32'(!scan_req && !m_busy && !reset));
            chk("clear_busy",  32'(clear_busy),  32'(m_busy));
            chk("clear_done",  32'(clear_done),  32'(e_done));
            chk("drop_count",  32'(drop_count),  32'(m_drops));
            if (clear_done) n_done++;
        end
    end

    task automatic step();
        @(posedge pixclk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // One raster write attempt; wr_ready must be high since nothing else competes.
    task automatic raster(input int x, input int y, input logic [23:0] rgb);
        wr_valid = 1'b1; wr_x = 10'(x); wr_y = 9'(y); wr_rgb = rgb;
        settle();
        chk("raster_ready", 32'(wr_ready), 32'h1);
        step();
        wr_valid = 1'b0;
    endtask

    localparam logic [23:0] SCAN_EXP [5] = '{24'h0A0B0C, 24'h0B0D0F, 24'h0C0F12, 24'h0D1115, 24'h0E1318};

    initial begin
        bit found;
        int done_before;

        reset = 1'b1; scan_req = 0; scan_x = '0; scan_y = '0;
        wr_valid = 0; wr_x = '0; wr_y = '0; wr_rgb = '0;
        clear_start = 0; clear_rgb = '0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_busy",   32'(clear_busy), 32'h0);
        chk("rst_drop",   32'(drop_count), 32'h0);
        chk("rst_rvalid", 32'(scan_rvalid), 32'h0);
        chk("rst_ready",  32'(wr_ready), 32'h0);
        reset = 1'b0;
        step();

        // Single in-range raster write: (3,2) -> address 1283.
        raster(3, 2, 24'h00FF00);
        chk("w1_en",    32'(mem_en), 32'h1);
        chk("w1_we",    32'(mem_we), 32'h1);
        chk("w1_addr",  32'(mem_addr), 32'd1283);
        chk("w1_wdata", 32'(mem_wdata), 32'h00FF00);
        step();

        // Scan burst over row 0 while a raster write waits.
        wr_valid = 1'b1; wr_x = 10'd7; wr_y = 9'd1; wr_rgb = 24'h123456;
        scan_req = 1'b1; scan_y = 9'd0;
        for (int k = 0; k < 5; k++) begin
            scan_x = 10'(k);
            settle();
            chk("scan_wr_ready", 32'(wr_ready), 32'h0);
            if (k >= 2) begin
                chk("scan_rv_lit",   32'(scan_rvalid), 32'h1);
                chk("scan_data_lit", 32'(scan_rdata), 32'(SCAN_EXP[k-2]));
            end
            step();
        end
        scan_req = 1'b0;
        settle();
        chk("post_scan_ready", 32'(wr_ready), 32'h1);
        chk("scan_data_lit", 32'(scan_rdata), 32'(SCAN_EXP[3]));
        step();
        wr_valid = 1'b0;
        chk("scan_data_lit", 32'(scan_rdata), 32'(SCAN_EXP[4]));
        chk("held_wr_we",   32'(mem_we), 32'h1);
        chk("held_wr_addr", 32'(mem_addr), 32'd647);
        step();
        chk("scan_rv_end", 32'(scan_rvalid), 32'h0);

        // Out-of-range writes are consumed without touching the RAM.
        raster(640, 10, 24'hAAAAAA);
        chk("drop1_en", 32'(mem_en), 32'h0);
        raster(5, 480, 24'hBBBBBB);
        chk("drop2_en", 32'(mem_en), 32'h0);
        chk("drop_eq2", 32'(drop_count), 32'd2);
        raster(639, 3, 24'hCCCCCC);
        chk("edge_we",   32'(mem_we), 32'h1);
        chk("edge_addr", 32'(mem_addr), 32'd2559);
        raster(640, 0, 24'h010101);
        raster(0, 4, 24'h020202);
        chk("drop_eq4", 32'(drop_count), 32'd4);
        for (int i = 0; i < 14; i++) raster(700 + i, 0, 24'h0);
        chk("drop_sat", 32'(drop_count), 32'hF);
        step();

        // Clear sweep with a raster write in the start cycle and 50% scan traffic.
        clear_start = 1'b1; clear_rgb = 24'h102030;
        wr_valid = 1'b1; wr_x = 10'd1; wr_y = 9'd1; wr_rgb = 24'hABCDEF;
        settle();
        chk("clr_start_ready", 32'(wr_ready), 32'h1);
        step();
        clear_start = 1'b0; clear_rgb = 24'h0;
        chk("clr_wr_we",    32'(mem_we), 32'h1);
        chk("clr_wr_addr",  32'(mem_addr), 32'd641);
        chk("clr_wr_wdata", 32'(mem_wdata), 32'hABCDEF);
        chk("clr_busy",     32'(clear_busy), 32'h1);
        wc_clr = 1'b1;
        n_done = 0;
        step();
        wc_clr = 1'b0;
        found = 0;
        for (int i = 0; i < 8000; i++) begin
            scan_req = ~scan_req;
            scan_x = 10'($urandom_range(639, 0));
            scan_y = 9'($urandom_range(3, 0));
            clear_start = (i == 500);
            clear_rgb = (i == 500) ? 24'h777777 : 24'h0;
            step();
            if (clear_done) begin
                found = 1;
                break;
            end
        end
        wr_valid = 1'b0; scan_req = 1'b0; clear_start = 1'b0;
        chk("clr_finished", 32'(found), 32'h1);
        step();
        step();
        chk("clr_done_once", 32'(n_done), 32'd1);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (wcount[i] != 1 || tb_ram[i] != 24'h102030) bad++;
            end
            chk("clr_coverage_bad", 32'(bad), 32'h0);
        end

        // Reset partway through a sweep aborts it silently.
        clear_start = 1'b1; clear_rgb = 24'h0000FF;
        step();
        clear_start = 1'b0;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (mem_en && mem_we && mem_addr == AW'(999)) begin
                found = 1;
                break;
            end
        end
        chk("abort_reached", 32'(found), 32'h1);
        done_before = n_done;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy",   32'(clear_busy), 32'h0);
        chk("abort_mem_en", 32'(mem_en), 32'h0);
        for (int i = 0; i < 10; i++) step();
        chk("abort_no_done", 32'(n_done - done_before), 32'h0);

        // A fresh clear starts again from address 0.
        clear_start = 1'b1; clear_rgb = 24'h445566;
        step();
        clear_start = 1'b0;
        step();
        chk("restart_we",    32'(mem_we), 32'h1);
        chk("restart_addr",  32'(mem_addr), 32'h0);
        chk("restart_wdata", 32'(mem_wdata), 32'h445566);
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (clear_done) begin
                found = 1;
                break;
            end
        end
        chk("restart_done", 32'(found), 32'h1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Arbitrates one single-port synchronous framebuffer RAM (640x480, 24-bit RGB per pixel) among three requesters:
  - the display scan-out read stream feeding the TMDS encode/serialise path;
  - rasterizer pixel writes;
  - a built-in clear-screen engine.
- Scan-out has absolute priority so video never starves.
- Raster writes and the clear sweep use idle RAM cycles.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 19, framebuffer address width (H_ACTIVE*V_ACTIVE <= 2^ADDR_W).
- DROP_W, 16, width of the out-of-range drop counter.

Ports:
- pixclk  in  1  single clock, 25 MHz pixel clock domain.
- reset  in  1  synchronous, active-high reset.
- scan_req  in  1  scan-out read request for this cycle.
- scan_x  in  10  scan read column.
- scan_y  in  9  scan read row.
- scan_rvalid  out  1  scan read data valid.
- scan_rdata  out  24  {red,green,blue} read data.
- wr_valid  in  1  raster write valid.
- wr_ready  out  1  raster write accepted this cycle when high with wr_valid.
- wr_x  in  10  raster write column.
- wr_y  in  9  raster write row.
- wr_rgb  in  24  raster write colour.
- clear_start  in  1  one-cycle pulse: fill the framebuffer with clear_rgb.
- clear_rgb  in  24  clear colour, sampled on accepted clear_start.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse when the sweep completes.
- drop_count  out  DROP_W  saturating count of out-of-range raster writes.
- mem_en  out  1  RAM port enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_wdata  out  24  RAM write data (registered).
- mem_rdata  in  24  RAM read data, valid 1 cycle after mem_en && !mem_we.

Behaviour:
- Clock and reset:
  - Single clock: pixclk.
  - Reset is synchronous and active-high, on the port named reset.
  - On reset, all outputs go to 0, the FSM goes to IDLE and the clear address goes to 0.
  - Reset during a clear aborts it. No clear_done pulse is issued.
- Address mapping: addr = y*H_ACTIVE + x.
  - Computed as (y<<9)+(y<<7)+x for the default parameters.
  - Result truncated to ADDR_W bits.
- Priority each cycle, highest first:
  - scan_req;
  - clear sweep (state CLEAR);
  - raster write (state IDLE).
- wr_ready = !scan_req && state==IDLE && !reset. It is combinational.
- Scan read:
  - scan_req in cycle N drives mem_en=1, mem_we=0 and the scan address in cycle N+1.
  - scan_rvalid=1 in cycle N+2, with scan_rdata=mem_rdata.
  - Back-to-back scan_req gives continuous rvalid with fixed 2-cycle latency.
  - Scan coordinates are never range-checked.
- Raster write:
  - On handshake, if wr_x<H_ACTIVE and wr_y<V_ACTIVE: mem_en=1, mem_we=1, addr and wdata driven in the next cycle.
  - Otherwise the write is consumed with no RAM access, and drop_count increments.
  - drop_count saturates at all-ones.
- FSM, states IDLE and CLEAR:
  - IDLE to CLEAR on clear_start. clear_rgb is latched and clear_addr is set to 0. clear_busy=1 from the next cycle.
  - A raster handshake in the same cycle as clear_start still completes.
  - In CLEAR, each cycle with scan_req=0 issues a write of the latched colour at clear_addr, then clear_addr increments.
  - Cycles with scan_req=1 stall the sweep.
  - When the write to address H_ACTIVE*V_ACTIVE-1 issues: go to IDLE, pulse clear_done for 1 cycle, drop clear_busy in the same cycle.
  - clear_start while in CLEAR is ignored. It does not restart the sweep or relatch the colour.
- When no requester is active: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last value.

Decomposition:
- Shared package fb_pkg:
  - H_ACTIVE, V_ACTIVE, FB_DEPTH=H_ACTIVE*V_ACTIVE, ADDR_W;
  - rgb_t (24-bit {r,g,b});
  - arbiter state enum {IDLE, CLEAR}.
- One sub-module, fb_addr_calc: combinational x,y to address mapping, instantiated twice (scan and raster).

Test Plan:
- Reset, then a single raster write of x=3, y=2, rgb=0x00FF00 with no scan:
  - wr_ready=1;
  - next cycle mem_en=1, mem_we=1, mem_addr=1283, mem_wdata=0x00FF00.
- scan_req held for 5 cycles over x=0..4, y=0 while wr_valid=1:
  - wr_ready=0 throughout;
  - scan_rvalid high in cycles 2..6, each data word matching model RAM;
  - the raster write completes in the first cycle after scan_req drops.
- Raster write at x=640, y=10, then at x=5, y=480:
  - both handshake with no RAM access;
  - drop_count=2.
  - Preload drop_count near saturation: it holds at 0xFFFF.
- clear_start with clear_rgb=0x102030, scan_req toggling 50%:
  - all 307200 addresses are written with 0x102030 exactly once;
  - clear_done pulses once;
  - wr_ready=0 while clear_busy=1;
  - a second clear_start mid-sweep is ignored.
- Reset asserted at clear_addr=1000:
  - next cycle clear_busy=0 and mem_en=0;
  - no clear_done pulse;
  - a subsequent clear_start restarts at address 0.
